snn_delay_layer: RTL and testbench

- Parametrised single spiking layer: M inputs, N leaky integrate-and-fire neurons, a programmable axonal delay per synapse and signed weights.
- Next-generation building block for multi-layer delayed SNN tops. Layers are cascaded by wiring out_spikes of one instance to in_spikes of the next.
- Delays are generalised to DBITS bits. The separate delay clock is replaced by a time-step strobe in the single clock domain.

---
 rtl/snn_delay_layer.sv | 120 ++++++++++++
 tb/tb_snn_delay_layer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_delay_layer.sv
// One layer of leaky integrate-and-fire neurons with programmable per-synapse axonal delays.
// All state advances only on an accepted time step (step & enable) within the single clock domain.
module snn_delay_layer #(
    parameter int M     = 24,
    parameter int N     = 8,
    parameter int NBITS = 4,
    parameter int DBITS = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     step,
    input  logic [M-1:0]             in_spikes,
    input  logic [M*N*NBITS-1:0]     weights,
    input  logic [M*N*DBITS-1:0]     delays,
    input  logic [M*N-1:0]           delay_en,
    input  logic [NBITS-1:0]         threshold,
    input  logic [NBITS-1:0]         decay,
    input  logic [NBITS-1:0]         refractory_period,
    output logic [N-1:0]             out_spikes,
    output logic [N*NBITS-1:0]       membrane_potential,
    output logic                     step_done
);
    localparam int HLEN = (1 << DBITS) - 1;
    localparam int SW   = NBITS + $clog2(M) + 2;
    localparam logic signed [SW-1:0] PMAX = SW'((1 << NBITS) - 1);

    logic            accept;
    logic [HLEN-1:0] hist_q [M];
    logic            done_q;

    assign accept    = step & enable;
    assign step_done = done_q;

    // hist_q[i][k-1] holds the input seen k accepted steps ago
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < M; i++) begin
                hist_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < M; i++) begin
                hist_q[i] <= (hist_q[i] << 1) | HLEN'(in_spikes[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= accept;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_neuron
            logic signed [SW-1:0]    sum_c;
            logic signed [SW-1:0]    p_c;
            logic [NBITS-1:0]        clamp_c;
            logic [NBITS-1:0]        pot_q, pot_d;
            logic [NBITS-1:0]        ref_q, ref_d;
            logic                    spk_q, spk_d;

            always_comb begin : syn_sum
                logic [DBITS-1:0]        dly;
                logic signed [NBITS-1:0] w;
                logic                    s;
                sum_c = '0;
                for (int i = 0; i < M; i++) begin
                    dly = delays[(gi*M+i)*DBITS +: DBITS];
                    w   = weights[(gi*M+i)*NBITS +: NBITS];
                    if (!delay_en[gi*M+i] || dly == '0) begin
                        s = in_spikes[i];
                    end else begin
                        s = hist_q[i][dly - 1'b1];
                    end
                    if (s) begin
                        sum_c = sum_c + SW'(w);
                    end
                end
            end

            // Leak and synaptic input are combined in the wide signed domain, then saturated
            always_comb begin : neuron_next
                p_c     = $signed(SW'(pot_q)) + sum_c - $signed(SW'(decay));
                clamp_c = (p_c < 0) ? '0 : ((p_c > PMAX) ? '1 : p_c[NBITS-1:0]);
                pot_d   = pot_q;
                ref_d   = ref_q;
                spk_d   = 1'b0;
                if (ref_q != '0) begin
                    ref_d = ref_q - 1'b1;
                    pot_d = '0;
                end else if (clamp_c >= threshold) begin
                    spk_d = 1'b1;
                    pot_d = '0;
                    ref_d = refractory_period;
                end else begin
                    pot_d = clamp_c;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pot_q <= '0;
                    ref_q <= '0;
                    spk_q <= 1'b0;
                end else if (accept) begin
                    pot_q <= pot_d;
                    ref_q <= ref_d;
                    spk_q <= spk_d;
                end
            end

            assign out_spikes[gi]                         = spk_q;
            assign membrane_potential[gi*NBITS +: NBITS]  = pot_q;
        end
    endgenerate
endmodule

// File: tb/tb_snn_delay_layer.sv
// Self-checking bench for snn_delay_layer: directed scenarios plus randomized steps against a queue-based model.
module tb_snn_delay_layer;
    localparam int M     = 4;
    localparam int N     = 2;
    localparam int NBITS = 4;
    localparam int DBITS = 3;
    localparam int HLEN  = (1 << DBITS) - 1;
    localparam int OW    = 1 + N + N*NBITS;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 enable = 1'b0;
    logic                 step = 1'b0;
    logic [M-1:0]         in_spikes = '0;
    logic [M*N*NBITS-1:0] weights = '0;
    logic [M*N*DBITS-1:0] delays = '0;
    logic [M*N-1:0]       delay_en = '0;
    logic [NBITS-1:0]     threshold = '0;
    logic [NBITS-1:0]     decay = '0;
    logic [NBITS-1:0]     refractory_period = '0;
    logic [N-1:0]         out_spikes;
    logic [N*NBITS-1:0]   membrane_potential;
    logic                 step_done;

    int checks = 0;
    int failures = 0;

    // Reference model state: past input vectors, newest first
    logic [M-1:0]       m_past[$];
    int                 m_pot[N];
    int                 m_ref[N];
    logic [N-1:0]       m_spk;
    logic [N*NBITS-1:0] m_potv;
    logic               exp_done;

    snn_delay_layer #(.M(M), .N(N), .NBITS(NBITS), .DBITS(DBITS)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .step(step),
        .in_spikes(in_spikes), .weights(weights), .delays(delays), .delay_en(delay_en),
        .threshold(threshold), .decay(decay), .refractory_period(refractory_period),
        .out_spikes(out_spikes), .membrane_potential(membrane_potential), .step_done(step_done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_past.delete();
        for (int j = 0; j < N; j++) begin
            m_pot[j] = 0;
            m_ref[j] = 0;
        end
        m_spk    = '0;
        m_potv   = '0;
        exp_done = 1'b0;
    endtask

    task automatic model_step();
        logic [N-1:0]            spk;
        logic signed [NBITS-1:0] wv;
        int                      sum, d, p, idx;
        bit                      s;
        spk = '0;
        for (int j = 0; j < N; j++) begin
            sum = 0;
            for (int i = 0; i < M; i++) begin
                idx = j*M + i;
                d   = delay_en[idx] ? int'(delays[idx*DBITS +: DBITS]) : 0;
                if (d == 0) s = in_spikes[i];
                else if (d <= m_past.size()) s = m_past[d-1][i];
                else s = 1'b0;
                wv = weights[idx*NBITS +: NBITS];
                if (s) sum += int'(wv);
            end
            if (m_ref[j] > 0) begin
                m_ref[j]--;
                m_pot[j] = 0;
            end else begin
                p = m_pot[j] + sum - int'(decay);
                if (p < 0) p = 0;
                if (p > (1 << NBITS) - 1) p = (1 << NBITS) - 1;
                if (p >= int'(threshold)) begin
                    spk[j]   = 1'b1;
                    m_pot[j] = 0;
                    m_ref[j] = int'(refractory_period);
                end else begin
                    m_pot[j] = p;
                end
            end
        end
        m_past.push_front(in_spikes);
        if (m_past.size() > HLEN) void'(m_past.pop_back());
        m_spk = spk;
        for (int j = 0; j < N; j++) m_potv[j*NBITS +: NBITS] = NBITS'(m_pot[j]);
    endtask

    // Drive one clock's inputs, let the edge pass, and advance the model if the step was accepted
    task automatic cycle(input bit stp, input bit en, input logic [M-1:0] in);
        @(negedge clk);
        step = stp;
        enable = en;
        in_spikes = in;
        @(posedge clk);
        #1;
        if (stp && en) model_step();
        exp_done = stp && en;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        step = 1'b0;
        enable = 1'b0;
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic clear_cfg();
        weights = '0;
        delays = '0;
        delay_en = '0;
        threshold = 4'd15;
        decay = '0;
        refractory_period = '0;
    endtask

    task automatic set_w(input int i, input int j, input logic [NBITS-1:0] v);
        weights[(j*M+i)*NBITS +: NBITS] = v;
    endtask

    task automatic test_reset();
        clear_cfg();
        set_w(0, 0, 4'd7);
        threshold = 4'd1;
        @(negedge clk);
        reset_n = 1'b0;
        step = 1'b0;
        #1;
        checks++;
        if ({step_done, out_spikes, membrane_potential} !== OW'(0)) begin
            failures++;
            $display("FAIL reset_hold: got %h expected 0", {step_done, out_spikes, membrane_potential});
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        cycle(1'b0, 1'b1, 4'hF);
        checks++;
        if ({step_done, out_spikes, membrane_potential} !== OW'(0)) begin
            failures++;
            $display("FAIL reset_idle: got %h expected 0", {step_done, out_spikes, membrane_potential});
        end
        cycle(1'b1, 1'b0, 4'hF);
        checks++;
        if ({step_done, out_spikes, membrane_potential} !== OW'(0)) begin
            failures++;
            $display("FAIL enable_low_step: got %h expected 0", {step_done, out_spikes, membrane_potential});
        end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_integration();
        int   ep[4] = '{2, 4, 6, 0};
        bit   es[4] = '{0, 0, 0, 1};
        logic [OW-1:0] ev;
        apply_reset();
        clear_cfg();
        set_w(0, 0, 4'd3);
        decay = 4'd1;
        threshold = 4'd8;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, 4'b0001);
            ev = {1'b1, 1'b0, es[k], 4'd0, 4'(ep[k])};
            checks++;
            if ({step_done, out_spikes, membrane_potential} !== ev) begin
                failures++;
                $display("FAIL integrate_step%0d: got %h expected %h", k+1, {step_done, out_spikes, membrane_potential}, ev);
            end
        end
        cycle(1'b0, 1'b1, 4'b0001);
        checks++;
        if ({step_done, out_spikes, membrane_potential} !== {1'b0, 2'b01, 8'h00}) begin
            failures++;
            $display("FAIL spike_hold_idle: got %h expected %h", {step_done, out_spikes, membrane_potential}, {1'b0, 2'b01, 8'h00});
        end
        $display("test_integration done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_delay();
        int dv[2] = '{5, 7};
        logic [OW-1:0] ev;
        for (int t = 0; t < 2; t++) begin
            apply_reset();
            clear_cfg();
            set_w(0, 0, 4'd7);
            threshold = 4'd7;
            delay_en[0] = 1'b1;
            delays[0 +: DBITS] = DBITS'(dv[t]);
            for (int k = 1; k <= dv[t] + 2; k++) begin
                cycle(1'b1, 1'b1, (k == 1) ? 4'b0001 : 4'b0000);
                ev = {1'b1, 1'b0, (k == dv[t] + 1), 8'h00};
                checks++;
                if ({step_done, out_spikes, membrane_potential} !== ev) begin
                    failures++;
                    $display("FAIL delay%0d_step%0d: got %h expected %h", dv[t], k, {step_done, out_spikes, membrane_potential}, ev);
                end
            end
        end
        $display("test_delay done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_refractory_clamp();
        bit es[4] = '{1, 0, 0, 1};
        logic [OW-1:0] ev;
        apply_reset();
        clear_cfg();
        for (int i = 0; i < 3; i++) set_w(i, 0, 4'd7);
        threshold = 4'd15;
        refractory_period = 4'd2;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, 4'b0111);
            ev = {1'b1, 1'b0, es[k], 8'h00};
            checks++;
            if ({step_done, out_spikes, membrane_potential} !== ev) begin
                failures++;
                $display("FAIL refractory_step%0d: got %h expected %h", k+1, {step_done, out_spikes, membrane_potential}, ev);
            end
        end
        $display("test_refractory_clamp done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_negative_weight();
        apply_reset();
        clear_cfg();
        threshold = 4'd8;
        set_w(1, 1, 4'd3);
        set_w(0, 1, 4'hC);
        cycle(1'b1, 1'b1, 4'b0010);
        checks++;
        if ({out_spikes, membrane_potential} !== {2'b00, 4'd3, 4'd0}) begin
            failures++;
            $display("FAIL neg_setup: got %h expected %h", {out_spikes, membrane_potential}, {2'b00, 4'd3, 4'd0});
        end
        cycle(1'b1, 1'b1, 4'b0001);
        checks++;
        if ({out_spikes, membrane_potential} !== 10'h000) begin
            failures++;
            $display("FAIL neg_clamp_zero: got %h expected 000", {out_spikes, membrane_potential});
        end
        $display("test_negative_weight done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        clear_cfg();
        set_w(0, 0, 4'd7);
        threshold = 4'd7;
        delay_en[0] = 1'b1;
        delays[0 +: DBITS] = 3'd5;
        cycle(1'b1, 1'b1, 4'b0001);
        cycle(1'b1, 1'b1, 4'b0000);
        @(negedge clk);
        step = 1'b0;
        reset_n = 1'b0;
        #2;
        checks++;
        if ({step_done, out_spikes, membrane_potential} !== OW'(0)) begin
            failures++;
            $display("FAIL midrun_async_clear: got %h expected 0", {step_done, out_spikes, membrane_potential});
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cycle(1'b1, 1'b1, 4'b0000);
            checks++;
            if ({out_spikes, membrane_potential} !== 10'h000) begin
                failures++;
                $display("FAIL midrun_lost_spike_step%0d: got %h expected 000", k+1, {out_spikes, membrane_potential});
            end
        end
        $display("test_reset_mid_run done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_back_to_back_random();
        bit stp, en;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if (c % 25 == 0) begin
                weights           = $urandom;
                delays            = $urandom;
                delay_en          = $urandom;
                threshold         = ($urandom_range(0, 7) == 0) ? 4'd0 : NBITS'($urandom_range(1, 15));
                decay             = NBITS'($urandom_range(0, 3));
                refractory_period = NBITS'($urandom_range(0, 3));
            end
            stp = ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 7) != 0);
            cycle(stp, en, M'($urandom));
            checks++;
            if ({step_done, out_spikes, membrane_potential} !== {exp_done, m_spk, m_potv}) begin
                failures++;
                $display("FAIL random_cycle%0d: got %h expected %h", c, {step_done, out_spikes, membrane_potential}, {exp_done, m_spk, m_potv});
            end
        end
        $display("test_back_to_back_random done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_integration();
        test_delay();
        test_refractory_clamp();
        test_negative_weight();
        test_reset_mid_run();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
